// File: rtl/mdu_ctrl.sv
// Iterative shift-add multiplier for MIPS mult/multu with HI/LO registers and mthi/mtlo writes.
// Define MDU_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
`timescale 1ns/1ps
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    input  logic             hilo_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int ACC_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ONE_ACC  = {{(ACC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             neg_r;

    logic [ACC_W-1:0] addend_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [ACC_W-1:0] result_s;
    logic [WIDTH-1:0] mplier_next_s;
    logic             run_last_s;

    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = (~v) + ONE_W;
        end else begin
            magnitude = v;
        end
    endfunction

    // One shift-add step, loop exit decision and sign fix-up of the final product.
    always_comb begin
        addend_s      = {{WIDTH{1'b0}}, mcand_r} << cnt_r;
        mplier_next_s = {1'b0, mplier_r[WIDTH-1:1]};
        if (mplier_r[0]) begin
            acc_next_s = acc_r + addend_s;
        end else begin
            acc_next_s = acc_r;
        end
`ifdef MDU_EARLY_TERM_EN
        run_last_s = (mplier_next_s == '0) || (cnt_r == LAST_CNT);
`else
        run_last_s = (cnt_r == LAST_CNT);
`endif
        if (neg_r) begin
            result_s = (~acc_r) + ONE_ACC;
        end else begin
            result_s = acc_r;
        end
    end

    // Control FSM with datapath registers and the HI/LO result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= magnitude(a, is_signed);
                        mplier_r <= magnitude(b, is_signed);
                        neg_r    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        state_r  <= RUN;
                    end else begin
                        if (wr_hi) begin
                            hi <= wd;
                        end
                        if (wr_lo) begin
                            lo <= wd;
                        end
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= mplier_next_s;
                    cnt_r    <= cnt_r + ONE_CNT;
                    if (run_last_s) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    {hi, lo} <= result_s;
                    done     <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (state_r != IDLE);
    assign stall = (hilo_req | wr_hi | wr_lo | start) & busy;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: an arithmetic reference model checked every cycle,
// plus literal expectations for products, latencies, stall and reset behaviour.
`timescale 1ns/1ps
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wd = 32'd0;
    logic        hilo_req = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit check_en = 1'b0;

`ifdef MDU_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
        .hilo_req(hilo_req), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: full 64-bit product straight from the operand values.
    function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx;
        longint sy;
        longint unsigned ux;
        longint unsigned uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return ux * uy;
    endfunction

    // Number of multiply-loop cycles the operation is allowed to take.
    function automatic int run_edges(input logic [31:0] y, input logic s);
        logic [31:0] m;
        int r;
        m = (s && y[31]) ? -y : y;
        r = 32;
        if (ET) begin
            r = 1;
            for (int i = 0; i < 32; i++) if (m[i]) r = i + 1;
        end
        return r;
    endfunction

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [63:0] m_prod = 64'd0;

    // Behavioural model: remaining-edge count until the result lands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0;
            m_left <= 0; m_prod <= 64'd0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_prod <= prod(a, b, is_signed);
                    m_left <= run_edges(b, is_signed) + 1;
                    m_busy <= 1'b1;
                end else begin
                    if (wr_hi) m_hi <= wd;
                    if (wr_lo) m_lo <= wd;
                end
            end else if (m_left == 1) begin
                m_hi <= m_prod[63:32];
                m_lo <= m_prod[31:0];
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (check_en) begin
            chk("cyc hi", hi, m_hi);
            chk("cyc lo", lo, m_lo);
            chk("cyc busy", busy, m_busy);
            chk("cyc done", done, m_done);
            chk("cyc stall", stall, (hilo_req | wr_hi | wr_lo | start) & m_busy);
        end
    end

    task automatic do_mul(input string nm, input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [31:0] eh, input logic [31:0] el, input int elat,
                          input bit inject, input logic [31:0] old_lo, input bit with_wr);
        int n;
        int dc0;
        @(posedge clk); #1;
        a = x; b = y; is_signed = s; start = 1'b1;
        if (with_wr) begin wr_hi = 1'b1; wd = 32'hDEADBEEF; end
        dc0 = done_cnt;
        @(posedge clk); #1;
        n = 1; start = 1'b0; wr_hi = 1'b0;
        while (!done && n < 200) begin
            if (inject && n == 3) begin
                start = 1'b1; wr_lo = 1'b1; wd = 32'h1234; hilo_req = 1'b1;
                a = 32'd100; b = 32'd100;
                #1 chk({nm, " stall"}, stall, 1'b1);
            end else if (inject && n == 4) begin
                start = 1'b0; wr_lo = 1'b0; hilo_req = 1'b0;
                chk({nm, " lo held"}, lo, old_lo);
            end
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, n, elat);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk({nm, " done pulses"}, done_cnt - dc0, 1);
    endtask

    initial begin
        int dc0;
        #12;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        rst_n = 1'b1;
        #10 check_en = 1'b1;

        @(posedge clk); #1;
        wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'hA5A5A5A5;
        #1 chk("mt stall", stall, 1'b0);
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mt hi", hi, 32'hA5A5A5A5);
        chk("mt lo", lo, 32'hA5A5A5A5);
        chk("mt done", done, 1'b0);

        do_mul("u ff*ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 34, 1'b0, 32'd0, 1'b0);
        do_mul("s -3*5", 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, ET ? 5 : 34, 1'b0, 32'd0, 1'b0);
        do_mul("s min*min", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 34, 1'b0, 32'd0, 1'b0);
        do_mul("s min*1", 32'h80000000, 32'd1, 1'b1, 32'hFFFFFFFF, 32'h80000000, ET ? 3 : 34, 1'b0, 32'd0, 1'b0);
        do_mul("u 3*4 inj", 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, ET ? 5 : 34, 1'b1, 32'h80000000, 1'b0);
        do_mul("u 2*3 wrhi", 32'd2, 32'd3, 1'b0, 32'd0, 32'd6, ET ? 4 : 34, 1'b0, 32'd0, 1'b1);

        @(posedge clk); #1;
        a = 32'd5; b = 32'd5; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #0.5;
        chk("rst busy", busy, 1'b0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        #0.5 rst_n = 1'b1;
        dc0 = done_cnt;
        repeat (40) @(posedge clk);
        #1 chk("rst no done", done_cnt - dc0, 0);

        do_mul("u 7*6", 32'd7, 32'd6, 1'b0, 32'd0, 32'd42, ET ? 5 : 34, 1'b0, 32'd0, 1'b0);
        do_mul("u 9*1", 32'd9, 32'd1, 1'b0, 32'd0, 32'd9, ET ? 3 : 34, 1'b0, 32'd0, 1'b0);
        do_mul("u 9*0", 32'd9, 32'd0, 1'b0, 32'd0, 32'd0, ET ? 3 : 34, 1'b0, 32'd0, 1'b0);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
